fsm_sequencer: RTL and testbench

//   Execution engine for the programmable FSM instruction memory.
//   - Drives the state address and evaluates the selected condition.
//   - Emits the then/else action and computes the next state.
//   - Owns the down-counters, loaded from the memory's constant field.
//   - Sits between the instruction memory (combinational read) and the chip action pins.
//   - Idles while the memory is being programmed.

---
 rtl/fsm_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fsm_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_sequencer.sv
// fsm_sequencer: execution engine for the programmable FSM instruction memory.
// Presents the current state address to a combinational-read memory, evaluates
// the selected condition, drives the registered then/else action and owns the
// reloadable down-counters and the slow-mode prescaler.
// Optional feature: define FSM_SEQ_SINGLE_STEP_EN to add step_mode/step inputs
// for one-evaluation-per-pulse single stepping.
module fsm_sequencer #(
  parameter  int STATE_COUNT   = 8,
  parameter  int COND_WIDTH    = 2,
  parameter  int ACTION_WIDTH  = 4,
  parameter  int COUNTER_WIDTH = 16,
  parameter  int COUNTER_COUNT = 2,
  parameter  int IN_WIDTH      = 1,
  parameter  int SLOW_SHIFT    = 4,
  localparam int SW            = $clog2(STATE_COUNT)
) (
  input  logic                                   clock,
  input  logic                                   rst_n,
  input  logic                                   run,
  input  logic                                   prog_enable,
  input  logic [IN_WIDTH-1:0]                    cond_in,
  output logic [SW-1:0]                          addr,
  input  logic [SW-1:0]                          jump_target,
  input  logic                                   repeat_state,
  input  logic                                   slow_mode,
  input  logic [COND_WIDTH-1:0]                  cond,
  input  logic [ACTION_WIDTH-1:0]                then_action,
  input  logic [ACTION_WIDTH-1:0]                else_action,
  input  logic [COUNTER_WIDTH*COUNTER_COUNT-1:0] const_data,
  output logic [ACTION_WIDTH-1:0]                action,
  output logic                                   busy,
`ifdef FSM_SEQ_SINGLE_STEP_EN
  input  logic                                   step_mode,
  input  logic                                   step,
`endif
  output logic                                   tick
);

  // Condition source vector: bit 0 always true, then counter-zero flags, then inputs.
  localparam int SRC_W = IN_WIDTH + COUNTER_COUNT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [SW-1:0]            addr_next;
  logic [ACTION_WIDTH-1:0]  action_next;
  logic [SLOW_SHIFT-1:0]    prescaler, prescaler_next;
  logic [COUNTER_WIDTH-1:0] counter      [COUNTER_COUNT];
  logic [COUNTER_WIDTH-1:0] counter_next [COUNTER_COUNT];
  logic [COUNTER_COUNT-1:0] cnt_zero;
  logic [SRC_W-1:0]         src;
  logic                     cond_true;
  logic [SW-1:0]            jump_addr;
  logic [SW-1:0]            seq_addr;
  logic                     step_hold;
  logic                     step_pulse;

`ifdef FSM_SEQ_SINGLE_STEP_EN
  assign step_hold  = step_mode;
  assign step_pulse = step;
`else
  assign step_hold  = 1'b0;
  assign step_pulse = 1'b0;
`endif

  assign busy = (state == LOAD) || (state == RUN);
  assign src  = {cond_in, cnt_zero, 1'b1};

  // Out-of-range jump targets fall back to state 0; sequential advance wraps.
  assign jump_addr = (int'(jump_target) < STATE_COUNT) ? jump_target : '0;
  assign seq_addr  = (int'(addr) == STATE_COUNT - 1) ? '0 : addr + 1'b1;

  // Flag each counter that has reached zero.
  always_comb begin
    cnt_zero = '0;
    for (int i = 0; i < COUNTER_COUNT; i++) cnt_zero[i] = (counter[i] == '0);
  end

  // Select the condition source; indices beyond the source vector read as false.
  always_comb begin
    cond_true = 1'b0;
    for (int i = 0; i < SRC_W; i++) begin
      if (int'(cond) == i) cond_true = src[i];
    end
  end

  // Step strobe: only in RUN with no pending exit, paced by mode.
  always_comb begin
    tick = 1'b0;
    if (state == RUN && run && !prog_enable) begin
      if (step_hold)       tick = step_pulse;
      else if (!slow_mode) tick = 1'b1;
      else                 tick = (prescaler == '1);
    end
  end

  // Next-state and datapath update; everything holds unless a case below changes it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next     = state;
    addr_next      = addr;
    action_next    = action;
    prescaler_next = prescaler;
    counter_next   = counter;
    unique case (state)
      IDLE: if (run && !prog_enable) state_next = LOAD;
      LOAD: begin
        addr_next      = '0;
        prescaler_next = '0;
        for (int i = 0; i < COUNTER_COUNT; i++)
          counter_next[i] = const_data[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        state_next     = RUN;
      end
      RUN: begin
        if (!run || prog_enable) begin
          // Exit wins over any step; counters keep their values.
          state_next  = IDLE;
          addr_next   = '0;
          action_next = '0;
        end else begin
          prescaler_next = prescaler + 1'b1;
          if (tick) begin
            if (cond_true || !repeat_state) begin
              // Transition event (jump or advance): reload counters, restart prescaler.
              action_next    = cond_true ? then_action : else_action;
              addr_next      = cond_true ? jump_addr : seq_addr;
              prescaler_next = '0;
              for (int i = 0; i < COUNTER_COUNT; i++)
                counter_next[i] = const_data[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end else begin
              // Repeat in place: counters count down, saturating at zero.
              action_next = else_action;
              for (int i = 0; i < COUNTER_COUNT; i++)
                if (counter[i] != '0) counter_next[i] = counter[i] - 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (step_hold) prescaler_next = '0;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      action    <= '0;
      prescaler <= '0;
      // NOTE: the counter array is a handful of flops feeding condition logic, so it is reset like any register.
      for (int i = 0; i < COUNTER_COUNT; i++) counter[i] <= '0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      action    <= action_next;
      prescaler <= prescaler_next;
      counter   <= counter_next;
    end
  end

endmodule

// File: tb/tb_fsm_sequencer.sv
// Self-checking bench for fsm_sequencer: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model of the sequencer.
module tb_fsm_sequencer;

  localparam int SC = 8;
  localparam int SW = 3;
  localparam int CW = 2;
  localparam int AW = 4;
  localparam int KW = 16;
  localparam int KC = 2;
  localparam int IW = 1;
  localparam int SS = 4;

  logic           clock = 1'b0;
  logic           rst_n, run, prog_enable;
  logic [IW-1:0]  cond_in;
  logic [SW-1:0]  addr, jump_target;
  logic           repeat_state, slow_mode;
  logic [CW-1:0]  cond;
  logic [AW-1:0]  then_action, else_action, action;
  logic [KW*KC-1:0] const_data;
  logic           busy, tick;
  bit             step_mode_v = 1'b0;
  bit             step_v      = 1'b0;
`ifdef FSM_SEQ_SINGLE_STEP_EN
  logic           step_mode, step;
  assign step_mode = step_mode_v;
  assign step      = step_v;
`endif

  // Instruction memory contents, read combinationally at the DUT address.
  int mem_jump [SC];
  int mem_cond [SC];
  int mem_then [SC];
  int mem_else [SC];
  bit mem_rep  [SC];
  bit mem_slow [SC];

  assign jump_target  = SW'(mem_jump[addr]);
  assign repeat_state = mem_rep[addr];
  assign slow_mode    = mem_slow[addr];
  assign cond         = CW'(mem_cond[addr]);
  assign then_action  = AW'(mem_then[addr]);
  assign else_action  = AW'(mem_else[addr]);

  always #5 clock = ~clock;

  fsm_sequencer dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .run          (run),
    .prog_enable  (prog_enable),
    .cond_in      (cond_in),
    .addr         (addr),
    .jump_target  (jump_target),
    .repeat_state (repeat_state),
    .slow_mode    (slow_mode),
    .cond         (cond),
    .then_action  (then_action),
    .else_action  (else_action),
    .const_data   (const_data),
    .action       (action),
    .busy         (busy),
`ifdef FSM_SEQ_SINGLE_STEP_EN
    .step_mode    (step_mode),
    .step         (step),
`endif
    .tick         (tick)
  );

  // Reference model: phase 0 idle, 1 load, 2 run.
  int m_phase, m_addr, m_action, m_pre;
  int m_cnt [KC];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int const_slice(int i);
    return int'(const_data[i*KW +: KW]);
  endfunction

  // Condition source k: 0 true, 1..KC counter zero, then external inputs, else false.
  function automatic bit m_src(int k);
    if (k == 0)       return 1'b1;
    if (k <= KC)      return m_cnt[k-1] == 0;
    if (k <= KC + IW) return cond_in[k-1-KC];
    return 1'b0;
  endfunction

  function automatic bit m_tick();
    if (m_phase != 2 || !run || prog_enable) return 1'b0;
    if (step_mode_v) return step_v;
    if (!mem_slow[m_addr]) return 1'b1;
    return m_pre == (1 << SS) - 1;
  endfunction

  task automatic model_update();
    bit t;
    int a;
    t = m_tick();
    a = m_addr;
    if (!rst_n) begin
      m_phase = 0; m_addr = 0; m_action = 0; m_pre = 0;
      m_cnt = '{default: 0};
      return;
    end
    case (m_phase)
      0: if (run && !prog_enable) m_phase = 1;
      1: begin
        m_phase = 2; m_addr = 0; m_pre = 0;
        for (int i = 0; i < KC; i++) m_cnt[i] = const_slice(i);
      end
      default: begin
        if (!run || prog_enable) begin
          m_phase = 0; m_addr = 0; m_action = 0;
        end else begin
          m_pre = (m_pre + 1) % (1 << SS);
          if (t) begin
            if (m_src(mem_cond[a])) begin
              m_action = mem_then[a];
              m_addr   = (mem_jump[a] < SC) ? mem_jump[a] : 0;
              m_pre    = 0;
              for (int i = 0; i < KC; i++) m_cnt[i] = const_slice(i);
            end else begin
              m_action = mem_else[a];
              if (mem_rep[a]) begin
                for (int i = 0; i < KC; i++) if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
              end else begin
                m_addr = (a + 1) % SC;
                m_pre  = 0;
                for (int i = 0; i < KC; i++) m_cnt[i] = const_slice(i);
              end
            end
          end
        end
      end
    endcase
    if (step_mode_v) m_pre = 0;
  endtask

  // Called at a falling edge with inputs already applied; checks, advances model and DUT.
  task automatic cycle();
    #1;
    check("tick",   tick,   m_tick());
    check("busy",   busy,   m_phase != 0);
    check("addr",   addr,   m_addr);
    check("action", action, m_action);
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic fill_mem(input int cnd, input bit slow);
    for (int i = 0; i < SC; i++) begin
      mem_jump[i] = (i + 3) % SC;
      mem_rep[i]  = 1'b0;
      mem_slow[i] = slow;
      mem_cond[i] = cnd;
      mem_then[i] = i;
      mem_else[i] = 8 + i;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; prog_enable = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  int prev, n, w;

  initial begin
    rst_n = 1'b0; run = 1'b0; prog_enable = 1'b0; cond_in = '0; const_data = '0;
    fill_mem(3, 1'b0);
    @(negedge clock);
    model_update();
    @(posedge clock);
    @(negedge clock);

    // Sequential advance with else actions, including wrap 7 -> 0.
    rst_n = 1'b1; run = 1'b1;
    prev = -1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (prev == SC - 1) check("wrap", addr, 0);
      prev = int'(addr);
    end

    // Always-true jump from state 0.
    do_reset();
    mem_cond[0] = 0; mem_then[0] = 5; mem_jump[0] = 6;
    run = 1'b1;
    repeat (3) cycle();
    check("t2_addr", addr, 6);
    check("t2_action", action, 5);

    // Repeat in state 2 until counter 0 reaches zero.
    do_reset();
    fill_mem(3, 1'b0);
    mem_cond[2] = 1; mem_rep[2] = 1'b1; mem_jump[2] = 5;
    const_data = {16'd9, 16'd3};
    run = 1'b1;
    n = 0;
    while (int'(addr) != 2 && n < 20) begin cycle(); n++; end
    check("t3_reach", addr, 2);
    n = 0;
    while (int'(addr) == 2 && n < 20) begin cycle(); n++; end
    check("t3_dwell", n, 4);
    check("t3_jump", addr, 5);

    // Slow mode: one step every 16 cycles.
    do_reset();
    fill_mem(3, 1'b1);
    run = 1'b1;
    repeat (2) cycle();
    for (int k = 0; k < 2; k++) begin
      prev = int'(addr);
      n = 0;
      while (int'(addr) == prev && n < 40) begin cycle(); n++; end
      check("t4_period", n, 16);
    end

    // Programming pulse forces IDLE, then a fresh LOAD and restart at 0.
    fill_mem(3, 1'b0);
    repeat (3) cycle();
    prog_enable = 1'b1;
    cycle();
    check("t5_busy", busy, 0);
    check("t5_addr", addr, 0);
    check("t5_action", action, 0);
    prog_enable = 1'b0;
    cycle();
    check("t5_load", busy, 1);
    repeat (2) cycle();
    check("t5_restart", addr, 1);

`ifdef FSM_SEQ_SINGLE_STEP_EN
    // Single stepping: address moves only on step pulses.
    step_mode_v = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step_v = (i % 4 == 1);
      prev = int'(addr);
      cycle();
      if (int'(addr) != prev) n++;
    end
    check("t6_steps", n, 3);
    step_mode_v = 1'b0; step_v = 1'b0;
`endif

    // Randomized traffic against the model.
    const_data = {16'd2, 16'd1};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 6 == 0) begin
        w = int'($urandom % SC);
        mem_jump[w] = int'($urandom % SC);
        mem_rep[w]  = 1'($urandom % 2);
        mem_slow[w] = ($urandom % 8 == 0);
        mem_cond[w] = int'($urandom % 4);
        mem_then[w] = int'($urandom % 16);
        mem_else[w] = int'($urandom % 16);
      end
      if ($urandom % 20 == 0) const_data = {16'($urandom % 5), 16'($urandom % 5)};
      run         = ($urandom % 40 != 0);
      prog_enable = ($urandom % 60 == 0);
      rst_n       = ($urandom % 400 != 0);
      cond_in     = IW'($urandom);
`ifdef FSM_SEQ_SINGLE_STEP_EN
      if ($urandom % 100 == 0) step_mode_v = ~step_mode_v;
      step_v = ($urandom % 3 == 0);
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
